irrigation_sequencer: RTL and testbench
=======================================

IRRIGATION_SEQUENCER -- requirements
Module: irrigation_sequencer

Interface
REQ-001 Parameter SYNC_STAGES, default 2, synchronizer depth for the asynchronous start_btn/stop_btn inputs (legal 2..4).
REQ-002 Parameter BLANK_CYCLES, default 2, cycles after init_pulse during which timer_done is ignored (legal 1..7).
REQ-003 clk  input  1  system clock, rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start_btn  input  1  asynchronous start request, level.
REQ-006 type_sel  input  2  requested irrigation type: 00 sprinkler, 01 drip, 10 mist, 11 invalid.
REQ-007 timer_done  input  1  high when the downstream timer count is zero (timer clk_off).
REQ-008 state  output  2  current phase: 00 IDLE, 01 PREP, 10 IRRIG, 11 PURGE (drives timer state).
REQ-009 irrigation_type  output  2  type latched at start (drives timer irrigation_type).
REQ-010 pulse_transiction  output  1  one-cycle strobe on every phase entry.
REQ-011 init_pulse  output  1  one-cycle timer load strobe.
REQ-012 pump_on  output  1  high in PREP and IRRIG.
REQ-013 valve_open  output  1  high in IRRIG only.
REQ-014 purge_open  output  1  high in PURGE only.
REQ-015 busy  output  1  high whenever state != IDLE.

Function
REQ-016 start_btn SHALL pass a SYNC_STAGES flop synchronizer followed by a rising-edge detector; only the edge is a start event.
REQ-017 In IDLE, a start event with type_sel != 11 SHALL latch type_sel into irrigation_type and move to PREP on the next edge; with type_sel == 11 it SHALL be ignored.
REQ-018 Phase order SHALL be IDLE -> PREP -> IRRIG -> PURGE -> IDLE; no other transitions except abort (REQ-026).
REQ-019 On the cycle state takes a new value, pulse_transiction SHALL be 1; init_pulse SHALL be 1 the following cycle; both are otherwise 0.
REQ-020 After init_pulse, a blank counter SHALL suppress timer_done for BLANK_CYCLES cycles; the first sampled timer_done=1 after that SHALL advance the phase on the next edge.
REQ-021 Entry into IDLE SHALL also issue pulse_transiction then init_pulse (clears timer); IDLE ignores timer_done.
REQ-022 Start events in any non-IDLE phase SHALL be ignored; irrigation_type SHALL hold until the next accepted start.
REQ-023 pump_on/valve_open/purge_open/busy SHALL be registered decodes of the next state, changing on the same edge as state.
REQ-024 A start event and timer-driven transition never coexist (IDLE ignores timer_done); timer_done stuck high SHALL advance one phase per (2+BLANK_CYCLES) cycles, never faster.

Reset
REQ-025 rst_n low SHALL immediately force state=00, irrigation_type=00, all strobes and drive outputs 0, blank counter and synchronizer flops 0; after release, first start edge requires a synchronized 0->1 of start_btn.

Configuration
REQ-026 With IRRIG_ABORT_EN defined: input stop_btn (1 bit, async, synchronized as REQ-016) edge in PREP or IRRIG SHALL jump to PURGE with normal entry strobes; in PURGE/IDLE it is ignored; stop beats timer_done in the same cycle. Without it: port absent, no abort path.

Structure
REQ-027 Package irrig_pkg SHALL hold the state enum (IDLE/PREP/IRRIG/PURGE codes), irrigation type codes, and the INVALID_TYPE constant; the downstream timer shares these codes.
REQ-028 One sub-module, btn_sync_edge (SYNC_STAGES synchronizer plus rising-edge pulse), instantiated once per button.

Verification
REQ-029 Reset mid-IRRIG: all outputs 0 within the same cycle as rst_n fall, state=00 after release.
REQ-030 type_sel=01, start edge, timer_done=0 for 20 cycles then 1: state 00->01, pulse_transiction then init_pulse, irrigation_type=01, pump_on=1; advance to 10 exactly one cycle after timer_done sampled.
REQ-031 type_sel=11 + start edge: state stays 00, no strobes.
REQ-032 timer_done held 1 throughout, BLANK_CYCLES=2: phase transitions spaced 4 cycles, full cycle returns to 00.
REQ-033 Start edge during IRRIG with type_sel=10: ignored, irrigation_type unchanged.
REQ-034 IRRIG_ABORT_EN: stop edge in IRRIG coincident with timer_done=1 -> state 11, purge_open=1, valve_open=0.

Source files
------------

// File: rtl/irrig_pkg.sv
// Shared phase and irrigation-type codes for the sequencer and the downstream timer.
package irrig_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PREP  = 2'b01,
    ST_IRRIG = 2'b10,
    ST_PURGE = 2'b11
  } irrig_state_t;

  localparam logic [1:0] TYPE_SPRINKLER = 2'b00;
  localparam logic [1:0] TYPE_DRIP      = 2'b01;
  localparam logic [1:0] TYPE_MIST      = 2'b10;
  localparam logic [1:0] INVALID_TYPE   = 2'b11;

  // Wide enough to hold BLANK_CYCLES+1 for the largest legal BLANK_CYCLES (7).
  localparam int BLANK_W = 4;

endpackage

// File: rtl/btn_sync_edge.sv
// Multi-flop synchronizer for an asynchronous button, followed by a rising-edge pulse.
module btn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_last <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
      r_last <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_last;

endmodule

// File: rtl/irrigation_sequencer.sv
// Irrigation phase sequencer (IDLE -> PREP -> IRRIG -> PURGE) driving the shared timer.
// Optional IRRIG_ABORT_EN adds a stop_btn input that aborts PREP/IRRIG into PURGE.
module irrigation_sequencer
  import irrig_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int BLANK_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_btn,
`ifdef IRRIG_ABORT_EN
  input  logic       stop_btn,
`endif
  input  logic [1:0] type_sel,
  input  logic       timer_done,
  output logic [1:0] state,
  output logic [1:0] irrigation_type,
  output logic       pulse_transiction,
  output logic       init_pulse,
  output logic       pump_on,
  output logic       valve_open,
  output logic       purge_open,
  output logic       busy
);

  // Loaded on every phase entry: covers the strobe cycle plus BLANK_CYCLES after init_pulse's start.
  localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(BLANK_CYCLES + 1);

  irrig_state_t       r_state;
  irrig_state_t       w_next;
  logic [1:0]         r_type;
  logic [1:0]         w_type_next;
  logic [BLANK_W-1:0] r_blank;
  logic               r_pulse;
  logic               r_init;
  logic               r_pump;
  logic               r_valve;
  logic               r_purge;
  logic               r_busy;
  logic               w_start;
  logic               w_stop;
  logic               w_timer_ok;
  logic               w_change;
  logic               w_pump;
  logic               w_valve;
  logic               w_purge;
  logic               w_busy;

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_start_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_btn  (start_btn),
    .o_rise (w_start)
  );

`ifdef IRRIG_ABORT_EN
  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_stop_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_btn  (stop_btn),
    .o_rise (w_stop)
  );
`else
  assign w_stop = 1'b0;
`endif

  always_comb begin
    w_next      = r_state;
    w_type_next = r_type;
    w_timer_ok  = timer_done && (r_blank == '0);
    unique case (r_state)
      ST_IDLE: begin
        if (w_start && (type_sel != INVALID_TYPE)) begin
          w_next      = ST_PREP;
          w_type_next = type_sel;
        end
      end
      // Abort takes priority over a coincident timer expiry.
      ST_PREP:  if (w_stop) w_next = ST_PURGE; else if (w_timer_ok) w_next = ST_IRRIG;
      ST_IRRIG: if (w_stop || w_timer_ok) w_next = ST_PURGE;
      ST_PURGE: if (w_timer_ok) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
    w_change = (w_next != r_state);
    w_pump   = (w_next == ST_PREP) || (w_next == ST_IRRIG);
    w_valve  = (w_next == ST_IRRIG);
    w_purge  = (w_next == ST_PURGE);
    w_busy   = (w_next != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_type  <= TYPE_SPRINKLER;
      r_blank <= '0;
      r_pulse <= 1'b0;
      r_init  <= 1'b0;
      r_pump  <= 1'b0;
      r_valve <= 1'b0;
      r_purge <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_type  <= w_type_next;
      r_pulse <= w_change;
      r_init  <= r_pulse;
      if (w_change)
        r_blank <= BLANK_LOAD;
      else if (r_blank != '0)
        r_blank <= r_blank - BLANK_W'(1);
      r_pump  <= w_pump;
      r_valve <= w_valve;
      r_purge <= w_purge;
      r_busy  <= w_busy;
    end
  end

  assign state             = r_state;
  assign irrigation_type   = r_type;
  assign pulse_transiction = r_pulse;
  assign init_pulse        = r_init;
  assign pump_on           = r_pump;
  assign valve_open        = r_valve;
  assign purge_open        = r_purge;
  assign busy              = r_busy;

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Directed bench for irrigation_sequencer with a cycle-level phase model and literal spot checks.
module tb_irrigation_sequencer;

  localparam int S = 2;
  localparam int B = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_btn = 1'b0;
  logic       timer_done = 1'b0;
  logic [1:0] type_sel = 2'b00;
`ifdef IRRIG_ABORT_EN
  logic       stop_btn = 1'b0;
`endif
  logic [1:0] state;
  logic [1:0] irrigation_type;
  logic       pulse_transiction;
  logic       init_pulse;
  logic       pump_on;
  logic       valve_open;
  logic       purge_open;
  logic       busy;

  irrigation_sequencer #(.SYNC_STAGES(S), .BLANK_CYCLES(B)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start_btn         (start_btn),
`ifdef IRRIG_ABORT_EN
    .stop_btn          (stop_btn),
`endif
    .type_sel          (type_sel),
    .timer_done        (timer_done),
    .state             (state),
    .irrigation_type   (irrigation_type),
    .pulse_transiction (pulse_transiction),
    .init_pulse        (init_pulse),
    .pump_on           (pump_on),
    .valve_open        (valve_open),
    .purge_open        (purge_open),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase number, latched type, cycles since the last phase entry, raw button sample history.
  int         m_phase = 0;
  int         m_type  = 0;
  int         m_age   = 99;
  logic [4:0] hs = '0;
  logic [4:0] hp = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_type  = 0;
      m_age   = 99;
      hs      = '0;
      hp      = '0;
    end else begin
      bit st_ev;
      bit sp_ev;
      bit tmr_ok;
      int nxt;
      st_ev  = hs[S-1] && !hs[S];
      sp_ev  = hp[S-1] && !hp[S];
      hs     = {hs[3:0], start_btn};
`ifdef IRRIG_ABORT_EN
      hp     = {hp[3:0], stop_btn};
`endif
      tmr_ok = timer_done && (m_age >= B + 1);
      nxt    = m_phase;
      if (m_phase == 0) begin
        if (st_ev && type_sel != 2'b11) begin
          nxt    = 1;
          m_type = int'(type_sel);
        end
      end else if (sp_ev && m_phase != 3) begin
        nxt = 3;
      end else if (tmr_ok) begin
        nxt = (m_phase + 1) % 4;
      end
      if (nxt != m_phase) begin
        m_phase = nxt;
        m_age   = 0;
      end else if (m_age < 99) begin
        m_age++;
      end
    end
  end

  always @(negedge clk) begin
    check("m_state", 8'(state), 8'(m_phase));
    check("m_type", 8'(irrigation_type), 8'(m_type));
    check("m_pulse", 8'(pulse_transiction), 8'(m_age == 0));
    check("m_init", 8'(init_pulse), 8'(m_age == 1));
    check("m_pump", 8'(pump_on), 8'(m_phase == 1 || m_phase == 2));
    check("m_valve", 8'(valve_open), 8'(m_phase == 2));
    check("m_purge", 8'(purge_open), 8'(m_phase == 3));
    check("m_busy", 8'(busy), 8'(m_phase != 0));
  end

  task automatic wait_state(input logic [1:0] s, input int max_cycles);
    int k = 0;
    while (state !== s && k < max_cycles) begin
      @(posedge clk); #1;
      k++;
    end
    check("wait_state", 8'(state), 8'(s));
  endtask

  initial begin
    logic [1:0] seq [3];
    seq[0] = 2'b10; seq[1] = 2'b11; seq[2] = 2'b00;

    repeat (3) @(posedge clk); #1;
    check("rst_state", 8'(state), 8'd0);
    check("rst_pulse", 8'(pulse_transiction), 8'd0);
    check("rst_init", 8'(init_pulse), 8'd0);
    check("rst_busy", 8'(busy), 8'd0);
    @(negedge clk) rst_n = 1'b1;

    // Drip start, long timer, then a single timer_done sample
    @(negedge clk); type_sel = 2'b01; start_btn = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("A_state", 8'(state), 8'd1);
    check("A_pulse", 8'(pulse_transiction), 8'd1);
    check("A_init0", 8'(init_pulse), 8'd0);
    check("A_type", 8'(irrigation_type), 8'd1);
    check("A_pump", 8'(pump_on), 8'd1);
    @(posedge clk); #1;
    check("A_init1", 8'(init_pulse), 8'd1);
    check("A_pulse0", 8'(pulse_transiction), 8'd0);
    @(negedge clk); start_btn = 1'b0; timer_done = 1'b0;
    repeat (20) @(negedge clk);
    timer_done = 1'b1;
    @(posedge clk); #1;
    check("A_irrig", 8'(state), 8'd2);
    check("A_valve", 8'(valve_open), 8'd1);
    @(negedge clk); timer_done = 1'b0;

    // Start during IRRIG is ignored
    type_sel = 2'b10; start_btn = 1'b1;
    repeat (6) @(posedge clk); #1;
    check("busy_start_state", 8'(state), 8'd2);
    check("busy_start_type", 8'(irrigation_type), 8'd1);
    @(negedge clk); start_btn = 1'b0;

`ifdef IRRIG_ABORT_EN
    @(negedge clk); stop_btn = 1'b1;
    @(negedge clk);
    @(negedge clk); timer_done = 1'b1;
    @(posedge clk); #1;
    check("abort_state", 8'(state), 8'd3);
    check("abort_purge", 8'(purge_open), 8'd1);
    check("abort_valve", 8'(valve_open), 8'd0);
    @(negedge clk); stop_btn = 1'b0; timer_done = 1'b1;
    wait_state(2'b00, 30);
    @(negedge clk); timer_done = 1'b0;
    repeat (3) @(negedge clk);
    type_sel = 2'b00; start_btn = 1'b1;
    wait_state(2'b01, 10);
    @(negedge clk); start_btn = 1'b0; stop_btn = 1'b1;
    wait_state(2'b11, 10);
    @(negedge clk); stop_btn = 1'b0; timer_done = 1'b1;
    wait_state(2'b00, 30);
    @(negedge clk); timer_done = 1'b0;
`else
    @(negedge clk); timer_done = 1'b1;
    @(posedge clk); #1;
    check("purge_state", 8'(state), 8'd3);
    check("purge_open", 8'(purge_open), 8'd1);
    check("purge_valve", 8'(valve_open), 8'd0);
    wait_state(2'b00, 30);
    @(negedge clk); timer_done = 1'b0;
`endif

    // Invalid type is ignored
    repeat (4) @(negedge clk);
    type_sel = 2'b11; start_btn = 1'b1;
    repeat (6) @(posedge clk); #1;
    check("inv_state", 8'(state), 8'd0);
    check("inv_busy", 8'(busy), 8'd0);
    @(negedge clk); start_btn = 1'b0;

    // timer_done stuck high: one phase per 2+BLANK_CYCLES cycles
    repeat (4) @(negedge clk);
    type_sel = 2'b00; timer_done = 1'b1; start_btn = 1'b1;
    wait_state(2'b01, 10);
    for (int t = 0; t < 3; t++) begin
      logic [1:0] prev;
      int cnt;
      prev = state;
      cnt  = 0;
      while (state === prev && cnt < 20) begin
        @(posedge clk); #1;
        cnt++;
      end
      check("stuck_spacing", 8'(cnt), 8'(2 + B));
      check("stuck_next", 8'(state), 8'(seq[t]));
    end
    repeat (6) @(posedge clk); #1;
    check("stuck_idle", 8'(state), 8'd0);
    @(negedge clk); start_btn = 1'b0; timer_done = 1'b0;

    // Reset in the middle of IRRIG
    repeat (4) @(negedge clk);
    type_sel = 2'b10; timer_done = 1'b1; start_btn = 1'b1;
    wait_state(2'b10, 20);
    @(negedge clk); start_btn = 1'b0; timer_done = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_state", 8'(state), 8'd0);
    check("mid_rst_type", 8'(irrigation_type), 8'd0);
    check("mid_rst_pump", 8'(pump_on), 8'd0);
    check("mid_rst_valve", 8'(valve_open), 8'd0);
    check("mid_rst_busy", 8'(busy), 8'd0);
    check("mid_rst_strobes", 8'({pulse_transiction, init_pulse, purge_open}), 8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_state", 8'(state), 8'd0);

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
